// File: rtl/memoria_solicitudes.sv
// Elevator request memory: latches button presses and feeds one code at a time to the floor FSM.
// Optional macro SWEEP_EN enables direction-aware floor selection instead of fixed priority.
module memoria_solicitudes #(
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] btn,
  input  logic [1:0] piso,
  input  logic [1:0] accion,
  input  logic       puertas,
  output logic [3:0] memoria,
  output logic [9:0] pendientes
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DWELL
  } state_t;

  state_t           state;
  logic [9:0]       s1, s2, s3;
  logic [9:0]       rise;
  logic [9:0]       clr;
  logic [3:0]       target;
  logic [3:0]       pick;
  logic [CNT_W-1:0] cnt;
  logic             expire;

  function automatic logic [9:0] floor_mask(input logic [1:0] f);
    logic [9:0] m;
    unique case (f)
      2'd0: m = 10'b00_0001_0001;
      2'd1: m = 10'b00_0110_0010;
      2'd2: m = 10'b01_1000_0100;
      2'd3: m = 10'b10_0000_1000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] code_floor(input logic [3:0] c);
    logic [1:0] f;
    unique case (c)
      4'd1, 4'd5:        f = 2'd0;
      4'd2, 4'd6, 4'd7:  f = 2'd1;
      4'd3, 4'd8, 4'd9:  f = 2'd2;
      4'd4, 4'd10:       f = 2'd3;
      default:           f = 2'd0;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lowest(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 9; i >= 0; i--)
      if (v[i[3:0]]) r = 4'(i + 1);
    return r;
  endfunction

  // Two-stage synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise   = s2 & ~s3;
  assign expire = en && (state == DWELL) &&
                  (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign clr    = expire ? floor_mask(code_floor(target)) : 10'd0;

  // Clear wins over a coincident new press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pendientes <= '0;
    else      pendientes <= (pendientes | rise) & ~clr;
  end

`ifdef SWEEP_EN
  logic       dir_up;
  logic [9:0] fmask [4];
  logic [3:0] has;
  logic [1:0] up_f, dn_f, sel_f;
  logic       up_ok, dn_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dir_up <= 1'b1;
    else if (accion == 2'd1) dir_up <= 1'b1;
    else if (accion == 2'd2) dir_up <= 1'b0;
  end

  always_comb begin
    for (int f = 0; f < 4; f++) begin
      fmask[f[1:0]] = pendientes & floor_mask(f[1:0]);
      has[f[1:0]]   = |fmask[f[1:0]];
    end
    up_ok = 1'b0;
    up_f  = 2'd0;
    dn_ok = 1'b0;
    dn_f  = 2'd0;
    for (int f = 3; f >= 0; f--)
      if (f > int'(piso) && has[f[1:0]]) begin
        up_ok = 1'b1;
        up_f  = f[1:0];
      end
    for (int f = 0; f < 4; f++)
      if (f < int'(piso) && has[f[1:0]]) begin
        dn_ok = 1'b1;
        dn_f  = f[1:0];
      end
    if (has[piso])   sel_f = piso;
    else if (dir_up) sel_f = up_ok ? up_f : dn_f;
    else             sel_f = dn_ok ? dn_f : up_f;
    pick = lowest(fmask[sel_f]);
  end
`else
  logic unused_accion;
  assign unused_accion = ^accion;
  assign pick = lowest(pendientes);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      target  <= 4'd0;
      memoria <= 4'd0;
      cnt     <= '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (|pendientes) begin
            target  <= pick;
            memoria <= pick;
            state   <= SERVE;
          end
        end
        SERVE: begin
          if (puertas && piso == code_floor(target)) begin
            cnt   <= '0;
            state <= DWELL;
          end
        end
        DWELL: begin
          cnt <= cnt + 1'b1;
          if (expire) begin
            memoria <= 4'd0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
